// File: rtl/param_dual_port_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | param_dual_port_ram: 1W/1R synchronous RAM, byte enables, HW clear       |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module param_dual_port_ram #(
   parameter int                DATA_W  = 8,
   parameter int                ADDR_W  = 6,
   parameter int                DEPTH   = 64,
   parameter int                BYTE_W  = 8,
   parameter int                RD_MODE = 0,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W/BYTE_W-1:0] wr_be,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   input  logic                     init_req,
   output logic                     init_busy
);

   localparam int                c_lanes     = DATA_W / BYTE_W;
   localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_last_ptr  = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   w_ptr_nxt;

   logic [DATA_W-1:0]   mem [0:DEPTH-1];

   logic                w_run;
   logic                w_wr_in_range;
   logic                w_rd_in_range;
   logic                w_wr_ok;
   logic                w_rd_ok;
   logic                w_collide;
   logic [DATA_W-1:0]   w_wr_old;
   logic [DATA_W-1:0]   w_wr_merged;
   logic [DATA_W-1:0]   w_rd_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         ST_INIT: begin
            w_ptr_nxt = r_ptr + ADDR_W'(1);
            if (r_ptr == c_last_ptr) begin
               w_state_nxt = ST_RUN;
               w_ptr_nxt   = '0;
            end
         end
         ST_RUN: begin
            if (init_req) begin
               w_state_nxt = ST_INIT;
               w_ptr_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_ptr_nxt   = '0;
         end
      endcase
   end

   assign w_run         = (r_state == ST_RUN);
   assign init_busy     = ~w_run;
   assign w_wr_in_range = ({1'b0, wr_addr} < c_depth_ext);
   assign w_rd_in_range = ({1'b0, rd_addr} < c_depth_ext);
   assign w_wr_ok       = w_run & wr_en & w_wr_in_range;
   assign w_rd_ok       = w_run & rd_en;
   assign w_collide     = wr_en & w_wr_in_range & (wr_addr == rd_addr);

   // Lane merge builds the full post-write word so the array takes whole-word writes.
   assign w_wr_old = w_wr_in_range ? mem[wr_addr] : CLR_VAL;

   for (genvar i = 0; i < c_lanes; i++) begin : g_lane
      assign w_wr_merged[i*BYTE_W +: BYTE_W] = wr_be[i] ? wr_data[i*BYTE_W +: BYTE_W]
                                                        : w_wr_old[i*BYTE_W +: BYTE_W];
   end

   always_comb begin
      w_rd_word = CLR_VAL;
      if (w_rd_in_range) begin
         if ((RD_MODE == 1) && w_collide) begin
            w_rd_word = w_wr_merged;
         end else begin
            w_rd_word = mem[rd_addr];
         end
      end
   end

   // The array has no reset; the sequencer owns the write port while not running.
   always_ff @(posedge clk) begin
      if (!w_run) begin
         mem[r_ptr] <= CLR_VAL;
      end else if (w_wr_ok) begin
         mem[wr_addr] <= w_wr_merged;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= w_rd_ok;
         if (w_rd_ok) begin
            rd_data <= w_rd_word;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_param_dual_port_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_param_dual_port_ram: directed checks of two RAM configurations        |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module tb_param_dual_port_ram;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Configuration A: 8-bit x 64, read-first
   logic        a_wr_en = 1'b0, a_rd_en = 1'b0, a_init_req = 1'b0;
   logic [5:0]  a_wr_addr = '0, a_rd_addr = '0;
   logic [7:0]  a_wr_data = '0;
   logic [0:0]  a_wr_be = '0;
   logic [7:0]  a_rd_data;
   logic        a_rd_valid, a_init_busy;

   // Configuration B: 32-bit x 48, write-first, non-zero clear value
   logic        b_wr_en = 1'b0, b_rd_en = 1'b0, b_init_req = 1'b0;
   logic [5:0]  b_wr_addr = '0, b_rd_addr = '0;
   logic [31:0] b_wr_data = '0;
   logic [3:0]  b_wr_be = '0;
   logic [31:0] b_rd_data;
   logic        b_rd_valid, b_init_busy;

   localparam logic [31:0] c_b_clr = 32'hDEADBEEF;

   param_dual_port_ram #(
      .DATA_W(8), .ADDR_W(6), .DEPTH(64), .BYTE_W(8), .RD_MODE(0), .CLR_VAL(8'h00)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
      .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
      .init_req(a_init_req), .init_busy(a_init_busy)
   );

   param_dual_port_ram #(
      .DATA_W(32), .ADDR_W(6), .DEPTH(48), .BYTE_W(8), .RD_MODE(1), .CLR_VAL(c_b_clr)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .init_req(b_init_req), .init_busy(b_init_busy)
   );

   typedef struct packed {
      logic       we;
      logic [5:0] wa;
      logic [7:0] wd;
      logic [0:0] be;
      logic       re;
      logic [5:0] ra;
      logic       ev;
      logic [7:0] ed;
   } vec_t;

   vec_t vecs [17];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_op(input logic we, input logic [5:0] wa, input logic [7:0] wd,
                       input logic be, input logic re, input logic [5:0] ra);
      a_wr_en = we; a_wr_addr = wa; a_wr_data = wd; a_wr_be = be;
      a_rd_en = re; a_rd_addr = ra;
      tick();
   endtask

   task automatic b_op(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [5:0] ra,
                       input logic ev, input logic [31:0] ed, input string nm);
      b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_wr_be = be;
      b_rd_en = re; b_rd_addr = ra;
      tick();
      chk({nm, "_valid"}, 32'(b_rd_valid), 32'(ev));
      chk({nm, "_data"}, b_rd_data, ed);
   endtask

   // Counts edges after reset release and checks where each clear sequence ends.
   task automatic wait_init();
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k <= 48) chk("b_init_valid", 32'(b_rd_valid), 32'd0);
         if (k == 47) chk("b_busy_47", 32'(b_init_busy), 32'd1);
         if (k == 48) begin
            chk("b_busy_48", 32'(b_init_busy), 32'd0);
            chk("b_init_hold", b_rd_data, 32'd0);
            b_rd_en = 1'b0;
         end
         if (k == 63) chk("a_busy_63", 32'(a_init_busy), 32'd1);
         if (k == 64) chk("a_busy_64", 32'(a_init_busy), 32'd0);
      end
   endtask

   initial begin
      //            we  wa     wd     be    re  ra     ev  ed
      vecs[0]  = '{1'b1, 6'd10, 8'h5A, 1'b1, 1'b0, 6'd0,  1'b0, 8'h00};
      vecs[1]  = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b1, 6'd10, 1'b1, 8'h5A};
      vecs[2]  = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b0, 6'd0,  1'b0, 8'h5A};
      vecs[3]  = '{1'b1, 6'd7,  8'h01, 1'b1, 1'b0, 6'd0,  1'b0, 8'h5A};
      vecs[4]  = '{1'b1, 6'd7,  8'hFF, 1'b1, 1'b1, 6'd7,  1'b1, 8'h01};
      vecs[5]  = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b1, 6'd7,  1'b1, 8'hFF};
      vecs[6]  = '{1'b1, 6'd7,  8'h33, 1'b0, 1'b0, 6'd0,  1'b0, 8'hFF};
      vecs[7]  = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b1, 6'd7,  1'b1, 8'hFF};
      vecs[8]  = '{1'b1, 6'd20, 8'hC3, 1'b1, 1'b1, 6'd10, 1'b1, 8'h5A};
      vecs[9]  = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b1, 6'd20, 1'b1, 8'hC3};
      vecs[10] = '{1'b1, 6'd5,  8'h77, 1'b1, 1'b0, 6'd0,  1'b0, 8'hC3};
      vecs[11] = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b1, 6'd5,  1'b1, 8'h77};
      vecs[12] = '{1'b1, 6'd63, 8'h9E, 1'b1, 1'b1, 6'd63, 1'b1, 8'h00};
      vecs[13] = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b1, 6'd63, 1'b1, 8'h9E};
      vecs[14] = '{1'b1, 6'd0,  8'h12, 1'b1, 1'b1, 6'd0,  1'b1, 8'h00};
      vecs[15] = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b1, 6'd0,  1'b1, 8'h12};
      vecs[16] = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b1, 6'd5,  1'b1, 8'h77};

      repeat (3) tick();
      chk("rst_a_data", 32'(a_rd_data), 32'd0);
      chk("rst_a_valid", 32'(a_rd_valid), 32'd0);
      chk("rst_a_busy", 32'(a_init_busy), 32'd1);
      chk("rst_b_data", b_rd_data, 32'd0);
      chk("rst_b_busy", 32'(b_init_busy), 32'd1);

      // Accesses held during the clear must be dropped
      b_rd_en = 1'b1;
      b_rd_addr = 6'd0;
      rst_n = 1'b1;
      wait_init();

      for (int i = 0; i < 64; i++) begin
         a_op(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 6'(i));
         chk("a_clr_valid", 32'(a_rd_valid), 32'd1);
         chk("a_clr_data", 32'(a_rd_data), 32'd0);
      end

      for (int i = 0; i < 17; i++) begin
         a_op(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].re, vecs[i].ra);
         if (a_rd_valid !== vecs[i].ev || a_rd_data !== vecs[i].ed) begin
            n_err++;
            $display("FAIL vec%0d: got valid=%b data=%h, expected valid=%b data=%h",
                     i, a_rd_valid, a_rd_data, vecs[i].ev, vecs[i].ed);
         end
         n_vec++;
      end

      // Clear request: the read in the request cycle still completes
      a_init_req = 1'b1;
      a_op(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 6'd5);
      chk("a_req_valid", 32'(a_rd_valid), 32'd1);
      chk("a_req_data", 32'(a_rd_data), 32'h77);
      chk("a_req_busy", 32'(a_init_busy), 32'd1);
      a_wr_en = 1'b1; a_wr_addr = 6'd5; a_wr_data = 8'hAA; a_wr_be = 1'b1;
      for (int k = 1; k <= 63; k++) begin
         tick();
         chk("a_clr_busy", 32'(a_init_busy), 32'd1);
         chk("a_clr_drop", 32'(a_rd_valid), 32'd0);
      end
      chk("a_clr_hold", 32'(a_rd_data), 32'h77);
      a_init_req = 1'b0;
      tick();
      chk("a_clr_done", 32'(a_init_busy), 32'd0);
      chk("a_clr_last", 32'(a_rd_valid), 32'd0);
      a_op(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 6'd5);
      chk("a_rd5_clr", 32'(a_rd_data), 32'h00);
      a_op(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 6'd10);
      chk("a_rd10_clr", 32'(a_rd_data), 32'h00);
      a_op(1'b1, 6'd1, 8'h4D, 1'b1, 1'b0, 6'd0);
      a_op(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 6'd1);
      chk("a_rd1", 32'(a_rd_data), 32'h4D);
      a_op(1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0);

      b_op(1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd0,  1'b1, c_b_clr,      "b_clr0");
      b_op(1'b1, 6'd3,  32'h11223344, 4'hF, 1'b0, 6'd0,  1'b0, c_b_clr,      "b_wr3a");
      b_op(1'b1, 6'd3,  32'hAABBCCDD, 4'h5, 1'b0, 6'd0,  1'b0, c_b_clr,      "b_wr3b");
      b_op(1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd3,  1'b1, 32'h11BB33DD, "b_be");
      b_op(1'b1, 6'd7,  32'h00000001, 4'hF, 1'b0, 6'd0,  1'b0, 32'h11BB33DD, "b_wr7");
      b_op(1'b1, 6'd7,  32'h000000FF, 4'hF, 1'b1, 6'd7,  1'b1, 32'h000000FF, "b_col_wf");
      b_op(1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd7,  1'b1, 32'h000000FF, "b_after_col");
      b_op(1'b1, 6'd7,  32'hAABBCCDD, 4'hA, 1'b1, 6'd7,  1'b1, 32'hAA00CCFF, "b_col_merge");
      b_op(1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd7,  1'b1, 32'hAA00CCFF, "b_merge_rd");
      b_op(1'b1, 6'd50, 32'h12345678, 4'hF, 1'b1, 6'd50, 1'b1, c_b_clr,      "b_oor_col");
      b_op(1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd50, 1'b1, c_b_clr,      "b_oor_rd");
      b_op(1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd48, 1'b1, c_b_clr,      "b_oor48");
      b_op(1'b1, 6'd47, 32'h0BADF00D, 4'hF, 1'b0, 6'd0,  1'b0, c_b_clr,      "b_wr47");
      b_op(1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd47, 1'b1, 32'h0BADF00D, "b_rd47");
      b_op(1'b0, 6'd0,  32'h0,        4'h0, 1'b0, 6'd0,  1'b0, 32'h0BADF00D, "b_idle");

      // Reset in the middle of a clear (B) and in the middle of normal running (A)
      b_init_req = 1'b1;
      tick();
      chk("b_req_busy", 32'(b_init_busy), 32'd1);
      b_init_req = 1'b0;
      repeat (20) tick();
      chk("b_mid_busy", 32'(b_init_busy), 32'd1);
      rst_n = 1'b0;
      #2;
      chk("arst_b_data", b_rd_data, 32'd0);
      chk("arst_b_busy", 32'(b_init_busy), 32'd1);
      chk("arst_a_data", 32'(a_rd_data), 32'd0);
      chk("arst_a_busy", 32'(a_init_busy), 32'd1);
      repeat (2) tick();
      rst_n = 1'b1;
      wait_init();

      b_op(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd7,  1'b1, c_b_clr, "b_rd7_reclr");
      b_op(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd47, 1'b1, c_b_clr, "b_rd47_reclr");
      a_op(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 6'd1);
      chk("a_rd1_reclr_v", 32'(a_rd_valid), 32'd1);
      chk("a_rd1_reclr", 32'(a_rd_data), 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
